// File: rtl/clock_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clock_div_pkg;

  localparam int NUM_CH_DEF       = 2;
  localparam int CNT_W_DEF        = 8;
  localparam int DEFAULT_HALF_DEF = 4;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int CH_W = ch_w(NUM_CH_DEF);

  typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: counter, active/pending half-period, registered clock.
// Optional tick output is built when CLKDIV_TICK_EN is defined.
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             iCLK,
  input  logic             RSTn,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             pend_vld,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick_out
`endif
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] half_r;
  logic [CNT_W-1:0] pend_val_r;
  logic             pend_vld_r;
  logic             clk_r;
  logic             run_s;
  logic             wrap_s;
  logic             apply_s;

  // A pending divisor lands only at the end of a full period, or at once when halted.
  always_comb begin
    run_s   = en && (half_r != '0);
    wrap_s  = run_s && (cnt_r == (half_r - CNT_W'(1)));
    apply_s = pend_vld_r && (run_s ? (wrap_s && clk_r) : 1'b1);
  end

  // Counter, output clock and divisor registers.
  always_ff @(posedge iCLK) begin
    if (!RSTn) begin
      cnt_r      <= '0;
      half_r     <= CNT_W'(DEFAULT_HALF);
      pend_val_r <= '0;
      pend_vld_r <= 1'b0;
      clk_r      <= 1'b0;
    end else begin
      if (!run_s) begin
        cnt_r <= '0;
        clk_r <= 1'b0;
      end else if (wrap_s) begin
        cnt_r <= '0;
        clk_r <= ~clk_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (apply_s) begin
        half_r     <= pend_val_r;
        pend_vld_r <= 1'b0;
      end else if (load) begin
        pend_val_r <= load_val;
        pend_vld_r <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_TICK_EN
  logic tick_r;

  // Pulse coincides with the first high cycle of each period.
  always_ff @(posedge iCLK) begin
    if (!RSTn) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= wrap_s && !clk_r;
    end
  end

  assign tick_out = tick_r;
`endif

  assign pend_vld = pend_vld_r;
  assign clk_out  = clk_r;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable 50%-duty clock divider with divisor update handshake.
// Define CLKDIV_TICK_EN to add the per-channel tick_out pulse port.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                      iCLK,
  input  logic                      RSTn,
  input  logic [NUM_CH-1:0]         en,
  input  logic [ch_w(NUM_CH)-1:0]   div_ch,
  input  logic [CNT_W-1:0]          div_val,
  input  logic                      div_valid,
  output logic                      div_ready,
  output logic [NUM_CH-1:0]         clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]         tick_out
`endif
);

  localparam int CHW = ch_w(NUM_CH);

  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] load_s;
  logic              ready_s;

  // Out-of-range channel selects match nothing, so they are accepted and dropped.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i] = (div_ch == CHW'(i));
    end
    ready_s = ~|(sel_s & pend_s);
    load_s  = sel_s & {NUM_CH{div_valid & ready_s}};
  end

  assign div_ready = ready_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .iCLK     (iCLK),
      .RSTn     (RSTn),
      .en       (en[g]),
      .load     (load_s[g]),
      .load_val (div_val),
      .pend_vld (pend_s[g]),
      .clk_out  (clk_out[g])
`ifdef CLKDIV_TICK_EN
      ,
      .tick_out (tick_out[g])
`endif
    );
  end

endmodule
